// File: rtl/display_pkg.sv
// Shared types and result codes for the switch-display controller.
package display_pkg;
   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_UPDATE} seq_state_t;
   typedef enum logic [1:0] {R_HEX, R_BCD, R_OVF, R_TMO} res_kind_t;

   localparam logic [15:0] OVERFLOW_CODE = 16'hE000;
   localparam logic [15:0] TIMEOUT_CODE  = 16'hEEEE;
   localparam logic [15:0] LED_OVERFLOW  = 16'hFFFF;
   localparam logic [15:0] LED_TIMEOUT   = 16'h00FF;
endpackage

// File: rtl/button_debouncer.sv
// Synchronizes one raw button, debounces it and emits a one-cycle pulse on release.
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic cmd
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1, sync2, stable, stable_d;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         stable   <= 1'b0;
         stable_d <= 1'b0;
         cnt      <= '0;
      end else begin
         sync1    <= btn;
         sync2    <= sync1;
         stable_d <= stable;
         // any return to the accepted level restarts the count
         if (sync2 == stable)
            cnt <= '0;
         else if (cnt == LAST) begin
            stable <= sync2;
            cnt    <= '0;
         end else
            cnt <= cnt + 1'b1;
      end
   end

   assign cmd = stable_d & ~stable;
endmodule

// File: rtl/display_seq_ctrl.sv
// Button commands, radix/source mode state and converter sequencing for the display.
module display_seq_ctrl
   import display_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REFRESH_CYCLES  = 1000000,
   parameter int TIMEOUT_CYCLES  = 64,
   parameter int MAX_DECIMAL     = 9999
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        btnU,
   input  logic        btnR,
   input  logic        btnL,
   input  logic [15:0] switches_inputs,
   output logic        conv_start,
   output logic [15:0] conv_bin,
   input  logic        conv_done,
   input  logic [15:0] conv_bcd,
   output logic [15:0] display_value,
   output logic [15:0] led_out,
   output logic        radix_dec,
   output logic        source_held,
   output logic        conv_error
);
   localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [15:0]   MAX_DEC  = 16'(MAX_DECIMAL);

   logic [2:0] btn_raw, cmd;
   assign btn_raw = {btnL, btnR, btnU};

   for (genvar i = 0; i < 3; i++) begin : g_btn
      button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk  (clk),
         .reset(reset),
         .btn  (btn_raw[i]),
         .cmd  (cmd[i])
      );
   end

   seq_state_t    state, state_nxt;
   res_kind_t     kind;
   logic [RW-1:0] refresh_cnt;
   logic [TW-1:0] tmo_cnt;
   logic [15:0]   hold, operand, bcd_q, op_sel;
   logic          force_pending, launch_conv;

   assign op_sel      = source_held ? hold : switches_inputs;
   assign launch_conv = radix_dec && (op_sel <= MAX_DEC);

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (force_pending || refresh_cnt == REF_LAST) state_nxt = S_LAUNCH;
         S_LAUNCH: state_nxt = launch_conv ? S_WAIT : S_UPDATE;
         S_WAIT:   if (conv_done || tmo_cnt == TMO_LAST) state_nxt = S_UPDATE;
         S_UPDATE: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hold          <= '0;
         radix_dec     <= 1'b0;
         source_held   <= 1'b0;
         force_pending <= 1'b1;
         refresh_cnt   <= '0;
         tmo_cnt       <= '0;
         operand       <= '0;
         bcd_q         <= '0;
         kind          <= R_HEX;
         conv_start    <= 1'b0;
         conv_bin      <= '0;
         conv_error    <= 1'b0;
         display_value <= '0;
         led_out       <= '0;
      end else begin
         if (cmd[2]) hold <= switches_inputs;
         if (cmd[0]) radix_dec <= ~radix_dec;
         if (cmd[1]) source_held <= ~source_held;
         // a command always wins over the clear on IDLE exit
         if (|cmd)
            force_pending <= 1'b1;
         else if (state == S_IDLE && state_nxt == S_LAUNCH)
            force_pending <= 1'b0;

         conv_start <= 1'b0;
         case (state)
            S_IDLE:
               refresh_cnt <= (state_nxt == S_LAUNCH) ? '0 : refresh_cnt + 1'b1;
            S_LAUNCH: begin
               operand <= op_sel;
               tmo_cnt <= '0;
               if (launch_conv) begin
                  conv_start <= 1'b1;
                  conv_bin   <= op_sel;
                  kind       <= R_BCD;
               end else
                  kind <= radix_dec ? R_OVF : R_HEX;
            end
            S_WAIT: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               if (conv_done)
                  bcd_q <= conv_bcd;
               else if (tmo_cnt == TMO_LAST) begin
                  kind       <= R_TMO;
                  conv_error <= 1'b1;
               end
            end
            S_UPDATE:
               case (kind)
                  R_HEX: begin display_value <= operand;       led_out <= '0;           end
                  R_BCD: begin display_value <= bcd_q;         led_out <= '0;           end
                  R_OVF: begin display_value <= OVERFLOW_CODE; led_out <= LED_OVERFLOW; end
                  R_TMO: begin display_value <= TIMEOUT_CODE;  led_out <= LED_TIMEOUT;  end
                  default: ;
               endcase
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_display_seq_ctrl.sv
// Scoreboard bench for display_seq_ctrl with a behavioural BCD converter peer.
module tb_display_seq_ctrl;
   logic        clk = 0, reset = 1;
   logic [2:0]  btn = '0;
   logic [15:0] sw = 16'h1234;
   logic        conv_start, conv_done = 0;
   logic [15:0] conv_bin, conv_bcd = '0, display_value, led_out;
   logic        radix_dec, source_held, conv_error;

   int n_chk = 0, n_pass = 0;
   int n_starts = 0;
   bit dbl = 0, prev_start = 0;
   bit conv_alive = 1;
   int conv_lat = 3;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   display_seq_ctrl #(.DEBOUNCE_CYCLES(4), .REFRESH_CYCLES(16), .TIMEOUT_CYCLES(8),
                      .MAX_DECIMAL(9999)) dut (
      .clk(clk), .reset(reset), .btnU(btn[0]), .btnR(btn[1]), .btnL(btn[2]),
      .switches_inputs(sw), .conv_start(conv_start), .conv_bin(conv_bin),
      .conv_done(conv_done), .conv_bcd(conv_bcd), .display_value(display_value),
      .led_out(led_out), .radix_dec(radix_dec), .source_held(source_held),
      .conv_error(conv_error));

   function automatic logic [15:0] bin2bcd(input logic [15:0] b);
      int v = int'(b);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", tag, act, exp);
   endtask

   // start-strobe monitor
   always @(negedge clk) begin
      if (conv_start) begin
         n_starts++;
         if (prev_start) dbl = 1;
      end
      prev_start = conv_start;
   end

   // converter peer: answers each start after conv_lat cycles
   always begin
      logic [15:0] b;
      @(negedge clk);
      if (conv_start && conv_alive) begin
         b = conv_bin;
         repeat (conv_lat) @(posedge clk);
         #1 conv_done = 1; conv_bcd = bin2bcd(b);
         @(posedge clk);
         #1 conv_done = 0;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input int idx);
      btn[idx] = 1; step(8);
      btn[idx] = 0; step(12);
   endtask

   task automatic wait_out(input string tag, input int max);
      logic [31:0] e;
      e = exp_q.pop_front();
      for (int i = 0; i < max && {display_value, led_out} !== e; i++) @(negedge clk);
      chk(tag, {display_value, led_out}, e);
   endtask

   task automatic wait_start(input int max, output bit ok, output logic [15:0] b);
      ok = 0; b = '0;
      for (int i = 0; i < max && !ok; i++) begin
         @(negedge clk);
         if (conv_start) begin ok = 1; b = conv_bin; end
      end
   endtask

   initial begin
      bit ok;
      logic [15:0] b;
      int lat, base;
      logic bounce [7] = '{1, 0, 1, 1, 1, 1, 1};

      // reset state
      step(3);
      @(negedge clk);
      chk("rst_out", {display_value, led_out}, 32'h0);
      chk("rst_flags", {28'h0, radix_dec, source_held, conv_error, conv_start}, 32'h0);

      // 1: HEX live after reset
      @(posedge clk); #1 reset = 0;
      lat = 0;
      while (display_value !== 16'h1234 && lat < 20) begin @(negedge clk); lat++; end
      chk("t1_lat_le4", {31'h0, lat <= 4}, 32'h1);
      exp_q.push_back({16'h1234, 16'h0});
      wait_out("t1_disp", 0);
      step(20);
      chk("t1_nostart", n_starts, 0);

      // 2: bouncy btnU -> DEC, convert 0x1234
      foreach (bounce[i]) begin btn[0] = bounce[i]; step(1); end
      step(3);
      btn[0] = 0;
      wait_start(60, ok, b);
      chk("t2_start", {31'h0, ok}, 32'h1);
      chk("t2_bin", {16'h0, b}, 32'h1234);
      exp_q.push_back({16'h4660, 16'h0});
      wait_out("t2_disp", 40);
      chk("t2_radix", {31'h0, radix_dec}, 32'h1);
      step(40);
      chk("t2_radix_once", {31'h0, radix_dec}, 32'h1);

      // 3: DEC overflow, then largest legal value
      sw = 16'h2710;
      exp_q.push_back({16'hE000, 16'hFFFF});
      wait_out("t3_ovf", 80);
      base = n_starts;
      step(40);
      chk("t3_nostart", n_starts - base, 0);
      chk("t3_ovf_hold", {display_value, led_out}, {16'hE000, 16'hFFFF});
      sw = 16'h270F;
      exp_q.push_back({16'h9999, 16'h0});
      wait_out("t3_9999", 80);

      // 4: capture, switch to held source, then move the switches
      sw = 16'h0042;
      press(2);
      press(1);
      sw = 16'hFFFF;
      step(40);
      chk("t4_src", {31'h0, source_held}, 32'h1);
      exp_q.push_back({16'h0066, 16'h0});
      wait_out("t4_dec", 80);
      press(0);
      exp_q.push_back({16'h0042, 16'h0});
      wait_out("t4_hex", 80);

      // 5: dead converter -> timeout, then recovery with sticky error
      conv_alive = 0;
      btn[0] = 1; step(8); btn[0] = 0;
      wait_start(60, ok, b);
      chk("t5_start", {31'h0, ok}, 32'h1);
      lat = 0;
      while (!conv_error && lat < 50) begin @(negedge clk); lat++; end
      chk("t5_tmo_lat", lat, 8);
      exp_q.push_back({16'hEEEE, 16'h00FF});
      wait_out("t5_tmo", 10);
      chk("t5_err", {31'h0, conv_error}, 32'h1);
      conv_alive = 1;
      exp_q.push_back({16'h0066, 16'h0});
      wait_out("t5_recover", 80);
      chk("t5_err_sticky", {31'h0, conv_error}, 32'h1);

      // 6: reset while waiting, converter answers just after reset
      conv_lat = 4;
      wait_start(60, ok, b);
      chk("t6_start", {31'h0, ok}, 32'h1);
      @(posedge clk); #1 reset = 1;
      @(negedge clk); @(negedge clk);
      chk("t6_rst_out", {display_value, led_out}, 32'h0);
      chk("t6_rst_flags", {28'h0, radix_dec, source_held, conv_error, conv_start}, 32'h0);
      @(posedge clk); #1 reset = 0;
      base = n_starts;
      exp_q.push_back({16'hFFFF, 16'h0});
      wait_out("t6_fresh", 4);
      step(30);
      chk("t6_nostart", n_starts - base, 0);
      chk("t6_err_clr", {31'h0, conv_error}, 32'h0);
      chk("t6_still", {display_value, led_out}, {16'hFFFF, 16'h0});
      chk("start_1cyc", {31'h0, dbl}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end
endmodule
